multiplicador_seq8: RTL and testbench



---
 rtl/multiplicador_seq8_pkg.sv | 15 +
 rtl/somador8bits.sv | 23 ++
 rtl/multiplicador_seq8.sv | 90 +++++++++
 tb/tb_multiplicador_seq8.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/multiplicador_seq8_pkg.sv
// Shared constants for the sequential 8x8 shift-and-add multiplier.
// State encodings are fixed two-bit codes so older netlists and waveforms still decode them.
package multiplicador_seq8_pkg;

  localparam int W      = 8;
  localparam int N_ITER = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_FIM  = 2'b10;

  // Counter value seen on the edge that performs the final iteration
  localparam logic [2:0] CNT_LAST = 3'(N_ITER - 1);

endpackage

// File: rtl/somador8bits.sv
// 8-bit ripple-carry adder: S = A + B + Cin, with the carry out of the top bit on Cout.
module somador8bits
  import multiplicador_seq8_pkg::*;
(
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] S,
  output logic         Cout
);

  logic [W:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[W];

endmodule

// File: rtl/multiplicador_seq8.sv
// Sequential 8x8 unsigned multiplier: one adder iteration per cycle over eight cycles,
// with a start/busy/done handshake and a product register that holds between results.
module multiplicador_seq8
  import multiplicador_seq8_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] P,
  output logic           busy,
  output logic           done
);

  logic [1:0]   st;
  logic [W-1:0] m;
  logic [W-1:0] acc;
  logic [W-1:0] q;
  logic [2:0]   cnt;

  logic [W-1:0] sum;
  logic         cout;
  logic         c_sel;
  logic [W-1:0] r_sel;
  logic [W-1:0] acc_nx;
  logic [W-1:0] q_nx;

  somador8bits u_somador (
    .A    (acc),
    .B    (m),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (cout)
  );

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    c_sel = 1'b0;
    r_sel = acc;
    if (q[0]) begin
      c_sel = cout;
      r_sel = sum;
    end
  end

  // The adder carry shifts into ACC's top bit, so no overflow is ever dropped
  assign acc_nx = {c_sel, r_sel[W-1:1]};
  assign q_nx   = {r_sel[0], q[W-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= ST_IDLE;
      m   <= '0;
      acc <= '0;
      q   <= '0;
      cnt <= '0;
      P   <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start) begin
            m   <= A;
            q   <= B;
            acc <= '0;
            cnt <= '0;
            st  <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc <= acc_nx;
          q   <= q_nx;
          cnt <= cnt + 3'd1;
          if (cnt == CNT_LAST) begin
            P  <= {acc_nx, q_nx};
            st <= ST_FIM;
          end
        end
        ST_FIM:  st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  // Pure decodes of the state register: start never reaches the outputs combinationally
  assign busy = (st == ST_CALC) || (st == ST_FIM);
  assign done = (st == ST_FIM);

endmodule

// File: tb/tb_multiplicador_seq8.sv
// Self-checking bench for multiplicador_seq8: vector table, cycle model with a result
// scoreboard, and hand sequences for held start, mid-operation reset and back-to-back use.
module tb_multiplicador_seq8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] P;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  multiplicador_seq8 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: acceptance only when idle, 9 busy cycles, product lands after the 8th edge
  logic [15:0] exp_q[$];
  int          mcnt    = 0;
  logic [15:0] pending = '0;
  logic [15:0] model_p = '0;
  bit          mon_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mcnt    = 0;
      model_p = '0;
      exp_q.delete();
    end else if (mcnt == 0) begin
      if (start) begin
        pending = {8'h00, A} * {8'h00, B};
        exp_q.push_back(pending);
        mcnt = 9;
      end
    end else begin
      mcnt--;
      if (mcnt == 1) model_p = pending;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(busy), 32'(mcnt != 0));
      check("done", 32'(done), 32'(mcnt == 1));
      check("p_hold", 32'(P), 32'(model_p));
      if (done === 1'b1) begin
        check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("sb_product", 32'(P), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation with a start pulse and wait (bounded) for done
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    A = a;
    B = b;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("done_timeout", 32'(lat > 0), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          lat;
    int          ndone;
    logic [15:0] p1;
    logic [15:0] p2;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'h008F};
    vecs[1] = '{a: 8'hFF,  b: 8'hFF,  p: 16'hFE01};
    vecs[2] = '{a: 8'h00,  b: 8'hFF,  p: 16'h0000};
    vecs[3] = '{a: 8'h80,  b: 8'h02,  p: 16'h0100};
    vecs[4] = '{a: 8'h01,  b: 8'h80,  p: 16'h0080};

    rst = 1'b1;
    start = 1'b1;
    A = 8'hFF;
    B = 8'hFF;
    step();
    step();
    check("rst_p", 32'(P), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    start = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Table vectors: latency and product, each followed by an idle cycle
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, lat);
      check("vec_latency", 32'(lat), 32'd8);
      check("vec_product", 32'(P), 32'(vecs[i].p));
      step();
      check("vec_idle_busy", 32'(busy), 32'h0);
      step();
    end

    // A few random operands, checked through the scoreboard
    for (int i = 0; i < 4; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), lat);
      step();
      step();
    end

    // Start held high through busy: operands changed after acceptance must not matter
    A = 8'd5;
    B = 8'd7;
    start = 1'b1;
    step();
    A = 8'hFF;
    B = 8'hFF;
    ndone = 0;
    p1 = '0;
    p2 = '0;
    for (int i = 1; i <= 19; i++) begin
      step();
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          p1 = P;
          check("held_first_at", 32'(i), 32'd8);
        end else begin
          p2 = P;
          check("held_second_at", 32'(i), 32'd18);
        end
      end
    end
    start = 1'b0;
    check("held_ndone", 32'(ndone), 32'd2);
    check("held_p1", 32'(p1), 32'h0023);
    check("held_p2", 32'(p2), 32'hFE01);
    repeat (12) step();

    // Reset on the 4th CALC cycle aborts the operation
    A = 8'hAA;
    B = 8'h55;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_p", 32'(P), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    repeat (12) step();
    do_op(8'd3, 8'd4, lat);
    check("after_abort_p", 32'(P), 32'h000C);
    step();
    step();

    // Back-to-back with start held: P keeps the first result until the second completes
    A = 8'd200;
    B = 8'd3;
    start = 1'b1;
    step();
    A = 8'd17;
    B = 8'd15;
    ndone = 0;
    for (int i = 1; i <= 19; i++) begin
      step();
      if (i == 8) check("b2b_first", 32'(P), 32'h0258);
      if (i > 8 && i < 18) check("b2b_hold", 32'(P), 32'h0258);
      if (i == 18) check("b2b_second", 32'(P), 32'h00FF);
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    check("b2b_ndone", 32'(ndone), 32'd2);
    repeat (12) step();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
